// File: rtl/match_controller.sv
// Best-of-N round sequencer: IDLE -> COUNTDOWN -> FIGHT -> ROUND_END ... -> MATCH_END.
// Owns its own tick divider, start-edge detector and pause handling.
module match_controller #(
    parameter int TICK_DIV       = 60,
    parameter int HW             = 3,
    parameter int TW             = 7,
    parameter int COUNTDOWN      = 3,
    parameter int ROUND_TIME     = 99,
    parameter int ROUND_END_TIME = 3,
    parameter int ROUNDS_TO_WIN  = 2,
    parameter int MAX_ROUNDS     = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          pause,
    input  logic [HW-1:0] p1_health,
    input  logic [HW-1:0] p2_health,
    output logic [2:0]    game_state,
    output logic [TW-1:0] timer,
    output logic [3:0]    round_num,
    output logic [3:0]    p1_score,
    output logic [3:0]    p2_score,
    output logic [1:0]    round_result,
    output logic [1:0]    match_winner,
    output logic          round_start,
    output logic          tick
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_FIGHT     = 3'd2,
        S_ROUND_END = 3'd3,
        S_MATCH_END = 3'd4
    } state_t;

    localparam int            DW          = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_LAST    = DW'(TICK_DIV - 1);
    localparam logic [TW-1:0] T_COUNTDOWN = TW'(COUNTDOWN);
    localparam logic [TW-1:0] T_FIGHT     = TW'(ROUND_TIME);
    localparam logic [TW-1:0] T_END       = TW'(ROUND_END_TIME);
    localparam logic [TW-1:0] T_ONE       = TW'(1);
    localparam logic [3:0]    WIN_SCORE   = 4'(ROUNDS_TO_WIN);
    localparam logic [3:0]    LAST_ROUND  = 4'(MAX_ROUNDS);
    localparam logic [1:0]    RES_NONE    = 2'd0;
    localparam logic [1:0]    RES_P1      = 2'd1;
    localparam logic [1:0]    RES_P2      = 2'd2;
    localparam logic [1:0]    RES_DRAW    = 2'd3;

    state_t        state_reg, state_next;
    logic [DW-1:0] div_reg;
    logic [TW-1:0] timer_reg, timer_next;
    logic [3:0]    round_num_reg, round_num_next;
    logic [3:0]    p1_score_reg, p1_score_next;
    logic [3:0]    p2_score_reg, p2_score_next;
    logic [1:0]    round_result_reg, round_result_next;
    logic          round_start_reg, round_start_next;
    logic          start_q_reg;

    logic       start_edge;
    logic       timed_state;
    logic       div_hold;
    logic       tick_int;
    logic       last_tick;
    logic       ko_p1;
    logic       ko_p2;
    logic       match_over;
    logic [1:0] fight_result;

    assign start_edge  = start & ~start_q_reg;
    assign timed_state = (state_reg == S_COUNTDOWN) || (state_reg == S_FIGHT) ||
                         (state_reg == S_ROUND_END);
    assign div_hold    = pause & timed_state;
    assign tick_int    = (div_reg == DIV_LAST) & ~div_hold;
    assign last_tick   = tick_int & (timer_reg == T_ONE);
    assign ko_p1       = (p1_health == '0);
    assign ko_p2       = (p2_health == '0);
    assign match_over  = (p1_score_reg >= WIN_SCORE) || (p2_score_reg >= WIN_SCORE) ||
                         (round_num_reg >= LAST_ROUND);

    // KO always outranks a timeout landing in the same cycle.
    always_comb begin
        fight_result = RES_NONE;
        if (ko_p1 && ko_p2) begin
            fight_result = RES_DRAW;
        end else if (ko_p1) begin
            fight_result = RES_P2;
        end else if (ko_p2) begin
            fight_result = RES_P1;
        end else if (last_tick) begin
            if (p1_health > p2_health) begin
                fight_result = RES_P1;
            end else if (p2_health > p1_health) begin
                fight_result = RES_P2;
            end else begin
                fight_result = RES_DRAW;
            end
        end
    end

    always_comb begin
        state_next        = state_reg;
        timer_next        = timer_reg;
        round_num_next    = round_num_reg;
        p1_score_next     = p1_score_reg;
        p2_score_next     = p2_score_reg;
        round_result_next = round_result_reg;
        round_start_next  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start_edge) begin
                    state_next        = S_COUNTDOWN;
                    timer_next        = T_COUNTDOWN;
                    round_num_next    = 4'd1;
                    p1_score_next     = 4'd0;
                    p2_score_next     = 4'd0;
                    round_result_next = RES_NONE;
                    round_start_next  = 1'b1;
                end
            end
            S_COUNTDOWN: begin
                if (last_tick) begin
                    state_next = S_FIGHT;
                    timer_next = T_FIGHT;
                end else if (tick_int && timer_reg != '0) begin
                    timer_next = timer_reg - T_ONE;
                end
            end
            S_FIGHT: begin
                if (fight_result != RES_NONE) begin
                    state_next        = S_ROUND_END;
                    timer_next        = T_END;
                    round_result_next = fight_result;
                    if (fight_result == RES_P1 && p1_score_reg < WIN_SCORE) begin
                        p1_score_next = p1_score_reg + 4'd1;
                    end
                    if (fight_result == RES_P2 && p2_score_reg < WIN_SCORE) begin
                        p2_score_next = p2_score_reg + 4'd1;
                    end
                end else if (tick_int && timer_reg != '0) begin
                    timer_next = timer_reg - T_ONE;
                end
            end
            S_ROUND_END: begin
                if (last_tick) begin
                    if (match_over) begin
                        state_next = S_MATCH_END;
                        timer_next = '0;
                    end else begin
                        state_next       = S_COUNTDOWN;
                        timer_next       = T_COUNTDOWN;
                        round_num_next   = round_num_reg + 4'd1;
                        round_start_next = 1'b1;
                    end
                end else if (tick_int && timer_reg != '0) begin
                    timer_next = timer_reg - T_ONE;
                end
            end
            S_MATCH_END: begin
                if (start_edge) begin
                    state_next        = S_IDLE;
                    timer_next        = '0;
                    round_num_next    = 4'd0;
                    p1_score_next     = 4'd0;
                    p2_score_next     = 4'd0;
                    round_result_next = RES_NONE;
                end
            end
            default: begin
                state_next        = S_IDLE;
                timer_next        = '0;
                round_num_next    = 4'd0;
                p1_score_next     = 4'd0;
                p2_score_next     = 4'd0;
                round_result_next = RES_NONE;
            end
        endcase
    end

    // start is sampled even while in reset, so a level held across release is not an edge.
    always_ff @(posedge clk) begin
        start_q_reg <= start;
        if (!reset) begin
            state_reg        <= S_IDLE;
            div_reg          <= '0;
            timer_reg        <= '0;
            round_num_reg    <= 4'd0;
            p1_score_reg     <= 4'd0;
            p2_score_reg     <= 4'd0;
            round_result_reg <= RES_NONE;
            round_start_reg  <= 1'b0;
        end else begin
            state_reg        <= state_next;
            timer_reg        <= timer_next;
            round_num_reg    <= round_num_next;
            p1_score_reg     <= p1_score_next;
            p2_score_reg     <= p2_score_next;
            round_result_reg <= round_result_next;
            round_start_reg  <= round_start_next;
            if (state_next != state_reg) begin
                div_reg <= '0;
            end else if (div_hold) begin
                div_reg <= div_reg;
            end else if (div_reg == DIV_LAST) begin
                div_reg <= '0;
            end else begin
                div_reg <= div_reg + DW'(1);
            end
        end
    end

    assign game_state   = state_reg;
    assign timer        = timer_reg;
    assign round_num    = round_num_reg;
    assign p1_score     = p1_score_reg;
    assign p2_score     = p2_score_reg;
    assign round_result = round_result_reg;
    assign round_start  = round_start_reg;
    assign tick         = tick_int;

    always_comb begin
        match_winner = 2'd0;
        if (state_reg == S_MATCH_END) begin
            if (p1_score_reg > p2_score_reg) begin
                match_winner = 2'd1;
            end else if (p2_score_reg > p1_score_reg) begin
                match_winner = 2'd2;
            end else begin
                match_winner = 2'd3;
            end
        end
    end

endmodule

// File: tb/tb_match_controller.sv
// Scoreboard bench for match_controller: a match-level model queues expected state
// transitions (with cycle gaps); a negedge monitor pops and compares them.
module tb_match_controller;

    localparam int TICK_DIV = 4;
    localparam int HW       = 3;
    localparam int TW       = 7;
    localparam int CD       = 3;
    localparam int RT       = 5;
    localparam int RET      = 2;
    localparam int RTW      = 2;
    localparam int MAXR     = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic [HW-1:0] p1_health = 3'd7;
    logic [HW-1:0] p2_health = 3'd7;
    logic [2:0]    game_state;
    logic [TW-1:0] timer;
    logic [3:0]    round_num;
    logic [3:0]    p1_score;
    logic [3:0]    p2_score;
    logic [1:0]    round_result;
    logic [1:0]    match_winner;
    logic          round_start;
    logic          tick;

    match_controller #(
        .TICK_DIV(TICK_DIV), .HW(HW), .TW(TW), .COUNTDOWN(CD), .ROUND_TIME(RT),
        .ROUND_END_TIME(RET), .ROUNDS_TO_WIN(RTW), .MAX_ROUNDS(MAXR)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause),
        .p1_health(p1_health), .p2_health(p2_health),
        .game_state(game_state), .timer(timer), .round_num(round_num),
        .p1_score(p1_score), .p2_score(p2_score), .round_result(round_result),
        .match_winner(match_winner), .round_start(round_start), .tick(tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st; int tmr; int rn; int s1; int s2; int rr; int mw; int rs; int gap;
    } rec_t;

    rec_t exp_q[$];
    int   act_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;

    function automatic rec_t mk(int st, int tmr, int rn, int s1, int s2, int rr,
                                int mw, int rs, int gap);
        rec_t r;
        r.st = st; r.tmr = tmr; r.rn = rn; r.s1 = s1; r.s2 = s2;
        r.rr = rr; r.mw = mw; r.rs = rs; r.gap = gap;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input int s, input string name);
        int n = 0;
        while (int'(game_state) != s && n < 200) begin
            step();
            n++;
        end
        chk(name, 32'(game_state), 32'(s));
    endtask

    // Monitor: one transaction per state change or round_start pulse.
    initial begin : monitor
        int   prev_st = 0;
        int   cyc = 0;
        int   last_cyc = 0;
        rec_t o;
        rec_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                if (int'(game_state) != prev_st || round_start === 1'b1) begin
                    o = mk(int'(game_state), int'(timer), int'(round_num), int'(p1_score),
                           int'(p2_score), int'(round_result), int'(match_winner),
                           int'(round_start), cyc - last_cyc);
                    last_cyc = cyc;
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_txn: got st=%0d tmr=%0d rn=%0d, required none",
                                 o.st, o.tmr, o.rn);
                    end else begin
                        e = exp_q.pop_front();
                        if (o.st != e.st || o.tmr != e.tmr || o.rn != e.rn || o.s1 != e.s1 ||
                            o.s2 != e.s2 || o.rr != e.rr || o.mw != e.mw || o.rs != e.rs ||
                            (e.gap >= 0 && o.gap != e.gap)) begin
                            fails++;
                            $display("FAIL txn: got st=%0d tmr=%0d rn=%0d sc=%0d:%0d rr=%0d mw=%0d rs=%0d gap=%0d, required st=%0d tmr=%0d rn=%0d sc=%0d:%0d rr=%0d mw=%0d rs=%0d gap=%0d",
                                     o.st, o.tmr, o.rn, o.s1, o.s2, o.rr, o.mw, o.rs, o.gap,
                                     e.st, e.tmr, e.rn, e.s1, e.s2, e.rr, e.mw, e.rs, e.gap);
                        end else begin
                            $display("[TB] txn ok st=%0d tmr=%0d rn=%0d sc=%0d:%0d rr=%0d mw=%0d gap=%0d",
                                     o.st, o.tmr, o.rn, o.s1, o.s2, o.rr, o.mw, o.gap);
                        end
                    end
                end
                prev_st = int'(game_state);
            end
        end
    end

    // Actions: 0 P1 KO, 1 P2 KO, 2 double KO, 3 timeout random, 4 timeout 4v6,
    // 5 timeout equal, 6 P1 KO in the same cycle as the timeout.
    task automatic play_match(input bit hold, input bit do_pause);
        int s1 = 0, s2 = 0, r = 1, rr = 0, act, res, h1, h2, w, p, k, tick_bad;
        bit done = 1'b0, ko;
        exp_q.push_back(mk(1, CD, 1, 0, 0, 0, 0, 1, -1));
        while (!done) begin
            if (act_q.size() > 0) act = act_q.pop_front();
            else act = int'($urandom_range(0, 6));
            h1 = 7; h2 = 7; w = int'($urandom_range(0, 18));
            case (act)
                3: begin h1 = int'($urandom_range(1, 7)); h2 = int'($urandom_range(1, 7)); end
                4: begin h1 = 4; h2 = 6; end
                5: begin h1 = int'($urandom_range(1, 7)); h2 = h1; end
                6: begin h1 = 7; h2 = 3; w = RT * TICK_DIV - 1; end
                default: ;
            endcase
            ko = (act <= 2) || (act == 6);
            if (act == 0 || act == 6) res = 2;
            else if (act == 1) res = 1;
            else if (act == 2) res = 3;
            else res = (h1 > h2) ? 1 : (h2 > h1) ? 2 : 3;
            p = (do_pause && r == 1) ? 10 : 0;
            k = int'($urandom_range(1, 8));
            exp_q.push_back(mk(2, RT, r, s1, s2, rr, 0, 0, CD * TICK_DIV + p));
            rr = res;
            if (res == 1) s1++;
            if (res == 2) s2++;
            exp_q.push_back(mk(3, RET, r, s1, s2, rr, 0, 0, ko ? w + 1 : RT * TICK_DIV));
            done = (s1 == RTW) || (s2 == RTW) || (r == MAXR);
            if (done)
                exp_q.push_back(mk(4, 0, r, s1, s2, rr, (s1 > s2) ? 1 : (s2 > s1) ? 2 : 3,
                                   0, RET * TICK_DIV));
            else
                exp_q.push_back(mk(1, CD, r + 1, s1, s2, rr, 0, 1, RET * TICK_DIV));
            p1_health = 3'(h1);
            p2_health = 3'(h2);
            if (r == 1) begin
                start = 1'b1;
                step();
                if (!hold) start = 1'b0;
            end
            wait_state(1, "reach_countdown");
            if (p > 0) begin
                repeat (k) step();
                pause = 1'b1;
                chk("pause_timer_in", 32'(timer), 32'(CD - k / TICK_DIV));
                tick_bad = 0;
                for (int i = 0; i < p; i++) begin
                    #1;
                    if (tick !== 1'b0) tick_bad++;
                    step();
                end
                pause = 1'b0;
                chk("pause_tick_frozen", 32'(tick_bad), 32'd0);
                chk("pause_timer_out", 32'(timer), 32'(CD - k / TICK_DIV));
            end
            wait_state(2, "reach_fight");
            if (ko) begin
                repeat (w) step();
                if (act == 0 || act == 6) p1_health = 3'd0;
                if (act == 1) p2_health = 3'd0;
                if (act == 2) begin p1_health = 3'd0; p2_health = 3'd0; end
            end
            wait_state(3, "reach_round_end");
            if (done) wait_state(4, "reach_match_end");
            else r++;
        end
        repeat (6) step();
        chk("match_end_held", 32'(game_state), 32'd4);
        chk("match_winner", 32'(match_winner), 32'((s1 > s2) ? 1 : (s2 > s1) ? 2 : 3));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, -1));
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_state(0, "back_to_idle");
        step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic reset_test();
        p1_health = 3'd7;
        p2_health = 3'd7;
        exp_q.push_back(mk(1, CD, 1, 0, 0, 0, 0, 1, -1));
        exp_q.push_back(mk(2, RT, 1, 0, 0, 0, 0, 0, CD * TICK_DIV));
        start = 1'b1;
        step();
        wait_state(1, "rst_reach_countdown");
        wait_state(2, "rst_reach_fight");
        repeat (3) step();
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, -1));
        reset = 1'b0;
        step();
        chk("rst_state", 32'(game_state), 32'd0);
        chk("rst_timer", 32'(timer), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_round_start", 32'(round_start), 32'd0);
        repeat (3) step();
        reset = 1'b1;
        repeat (10) step();
        chk("no_start_after_reset", 32'(game_state), 32'd0);
        start = 1'b0;
        step();
        chk("rst_queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        repeat (3) step();
        chk("init_state", 32'(game_state), 32'd0);
        chk("init_timer", 32'(timer), 32'd0);
        chk("init_round", 32'(round_num), 32'd0);
        chk("init_scores", 32'({p1_score, p2_score}), 32'd0);
        chk("init_results", 32'({round_result, match_winner}), 32'd0);
        chk("init_pulses", 32'({round_start, tick}), 32'd0);
        mon_en = 1'b1;
        reset = 1'b1;
        step();
        act_q = '{1, 1};
        play_match(1'b0, 1'b0);
        act_q = '{4, 5, 0};
        play_match(1'b0, 1'b0);
        act_q = '{2, 5, 2};
        play_match(1'b0, 1'b0);
        act_q = '{6};
        play_match(1'b1, 1'b1);
        reset_test();
        for (int m = 0; m < 8; m++) begin
            act_q.delete();
            play_match(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
